// File: rtl/prog_loader_pkg.sv
// Shared constants for the program loader: frame sync byte and FSM state codes.
package prog_loader_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_COUNT = 3'd1;
    localparam state_t ST_DATA  = 3'd2;
    localparam state_t ST_CHECK = 3'd3;
    localparam state_t ST_RUN   = 3'd4;
    localparam state_t ST_FAIL  = 3'd5;

endpackage

// File: rtl/prog_loader_word_asm.sv
// Byte-to-word assembler: little-endian shift register plus byte counter.
// Ports:
//   clk, reset      - clock, async active-low reset
//   clear           - drop any partially assembled word
//   accept          - din is consumed this cycle
//   din             - incoming byte
//   word_done_c     - this accept completes a word (combinational)
//   word_c          - assembled word including the byte being accepted
module loader_word_asm #(
    parameter int unsigned width = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             accept,
    input  logic [7:0]       din,
    output logic             word_done_c,
    output logic [width-1:0] word_c
);

    localparam int unsigned BPW   = width / 8;
    localparam int unsigned CNT_W = (BPW > 1) ? $clog2(BPW) : 1;

    logic [CNT_W-1:0] byte_cnt;
    logic [width-1:0] shreg;
    logic [width+7:0] cat;

    // New byte enters at the top, so the first byte ends up in the LSBs.
    assign cat         = {din, shreg};
    assign word_c      = cat[width+7:8];
    assign word_done_c = accept && (byte_cnt == CNT_W'(BPW - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            byte_cnt <= '0;
            shreg    <= '0;
        end else if (clear) begin
            byte_cnt <= '0;
        end else if (accept) begin
            shreg    <= word_c;
            byte_cnt <= word_done_c ? '0 : CNT_W'(byte_cnt + 1'b1);
        end
    end

endmodule

// File: rtl/prog_loader.sv
// Byte-stream program loader: parses SYNC/COUNT/words/CHK frames, writes the
// instruction RAM, and holds the CPU in reset until a verified image is loaded.
// Ports:
//   clk, reset                 - clock, async active-low reset
//   rx_data, rx_valid, rx_ready - byte input handshake
//   iaddr_write, idata_write, i_write - instruction RAM write port
//   cpu_hold                   - holds the CPU in reset
//   done, err                  - last frame loaded / failed checksum
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int unsigned width       = 16,
    parameter int unsigned iaddr_width = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [7:0]             rx_data,
    input  logic                   rx_valid,
    output logic                   rx_ready,
    output logic [iaddr_width-1:0] iaddr_write,
    output logic [width-1:0]       idata_write,
    output logic                   i_write,
    output logic                   cpu_hold,
    output logic                   done,
    output logic                   err
);

    localparam int unsigned WCNT_W = 9;

    state_t            state;
    state_t            state_d;
    logic [WCNT_W-1:0] words_left;
    logic [7:0]        sum;
    logic              accept;
    logic              data_acc;
    logic              word_done_c;
    logic [width-1:0]  word_c;
    logic              hold_d;
    logic              done_d;
    logic              err_d;

    assign accept   = rx_valid & rx_ready;
    assign data_acc = accept && (state == ST_DATA);

    loader_word_asm #(.width(width)) u_word_asm (
        .clk         (clk),
        .reset       (reset),
        .clear       (state != ST_DATA),
        .accept      (data_acc),
        .din         (rx_data),
        .word_done_c (word_done_c),
        .word_c      (word_c)
    );

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next state and next flag values
    always_comb begin
        state_d = state;
        hold_d  = cpu_hold;
        done_d  = done;
        err_d   = err;
        case (state)
            ST_IDLE, ST_RUN, ST_FAIL: begin
                if (accept && (rx_data == SYNC_BYTE)) begin
                    state_d = ST_COUNT;
                end
            end
            ST_COUNT: begin
                if (accept) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (word_done_c && (words_left == WCNT_W'(1))) begin
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (accept) begin
                    state_d = (8'(sum + rx_data) == 8'h00) ? ST_RUN : ST_FAIL;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (state_d == ST_COUNT && state != ST_COUNT) begin
            hold_d = 1'b1;
            done_d = 1'b0;
            err_d  = 1'b0;
        end else if (state_d == ST_RUN && state != ST_RUN) begin
            hold_d = 1'b0;
            done_d = 1'b1;
        end else if (state_d == ST_FAIL && state != ST_FAIL) begin
            err_d = 1'b1;
        end
    end

    // Datapath, write port and registered flags
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            words_left  <= '0;
            sum         <= '0;
            rx_ready    <= 1'b0;
            iaddr_write <= '0;
            idata_write <= '0;
            i_write     <= 1'b0;
            cpu_hold    <= 1'b1;
            done        <= 1'b0;
            err         <= 1'b0;
        end else begin
            // Stall input exactly during the write strobe cycle.
            rx_ready <= ~word_done_c;
            i_write  <= word_done_c;
            cpu_hold <= hold_d;
            done     <= done_d;
            err      <= err_d;
            if (word_done_c) begin
                idata_write <= word_c;
            end
            if (state == ST_COUNT && accept) begin
                // COUNT of zero encodes 256 words.
                words_left  <= (rx_data == 8'h00) ? WCNT_W'(256) : WCNT_W'(rx_data);
                sum         <= rx_data;
                iaddr_write <= '0;
            end else begin
                if (data_acc) begin
                    sum <= 8'(sum + rx_data);
                end
                if (word_done_c) begin
                    words_left <= WCNT_W'(words_left - 1'b1);
                end
                // Address advances after each write and wraps with the RAM depth.
                if (i_write) begin
                    iaddr_write <= iaddr_width'(iaddr_write + 1'b1);
                end
            end
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: frames are described as per-byte roles,
// a role-driven model predicts outputs every cycle, plus literal spot checks.
module tb_prog_loader;

    localparam logic [2:0] R_IGN   = 3'd0;
    localparam logic [2:0] R_SYNC  = 3'd1;
    localparam logic [2:0] R_PLAIN = 3'd2;
    localparam logic [2:0] R_WORD  = 3'd3;
    localparam logic [2:0] R_GOOD  = 3'd4;
    localparam logic [2:0] R_BAD   = 3'd5;

    typedef struct packed {
        logic [2:0]  kind;
        logic [7:0]  addr;
        logic [15:0] data;
    } role_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic [7:0]  iaddr_write;
    logic [15:0] idata_write;
    logic        i_write;
    logic        cpu_hold;
    logic        done;
    logic        err;

    int n_checks = 0;
    int n_fail   = 0;
    int gap_max  = 0;

    role_t       role_q[$];
    logic        exp_ready = 1'b0;
    logic        exp_wr    = 1'b0;
    logic [7:0]  exp_addr  = 8'h00;
    logic [15:0] exp_data  = 16'h0000;
    logic        exp_hold  = 1'b1;
    logic        exp_done  = 1'b0;
    logic        exp_err   = 1'b0;
    logic [15:0] ram [256];

    prog_loader #(.width(16), .iaddr_width(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .iaddr_write (iaddr_write),
        .idata_write (idata_write),
        .i_write     (i_write),
        .cpu_hold    (cpu_hold),
        .done        (done),
        .err         (err)
    );

    always #5 clk = ~clk;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic role_t mk(input logic [2:0] k, input logic [7:0] a, input logic [15:0] d);
        role_t r;
        r.kind = k;
        r.addr = a;
        r.data = d;
        return r;
    endfunction

    // Model: what each accepted byte means decides the outputs of the next cycle.
    initial begin
        role_t r;
        logic  acc;
        forever begin
            @(posedge clk or negedge reset);
            if (!reset) begin
                exp_ready = 1'b0;
                exp_wr    = 1'b0;
                exp_addr  = 8'h00;
                exp_data  = 16'h0000;
                exp_hold  = 1'b1;
                exp_done  = 1'b0;
                exp_err   = 1'b0;
                role_q.delete();
            end else begin
                acc       = rx_valid && exp_ready;
                exp_wr    = 1'b0;
                exp_ready = 1'b1;
                if (acc) begin
                    if (role_q.size() == 0) begin
                        check("unexpected_accept", 32'd1, 32'd0);
                    end else begin
                        r = role_q.pop_front();
                        case (r.kind)
                            R_SYNC: begin
                                exp_hold = 1'b1;
                                exp_done = 1'b0;
                                exp_err  = 1'b0;
                            end
                            R_WORD: begin
                                exp_wr    = 1'b1;
                                exp_ready = 1'b0;
                                exp_addr  = r.addr;
                                exp_data  = r.data;
                            end
                            R_GOOD: begin
                                exp_hold = 1'b0;
                                exp_done = 1'b1;
                            end
                            R_BAD: begin
                                exp_err = 1'b1;
                            end
                            default: begin
                            end
                        endcase
                    end
                end
            end
        end
    end

    // Per-cycle compare and RAM capture, sampled mid-cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset) begin
                check("rst_ready", 32'(rx_ready), 32'd0);
                check("rst_wr", 32'(i_write), 32'd0);
                check("rst_addr", 32'(iaddr_write), 32'd0);
                check("rst_data", 32'(idata_write), 32'd0);
                check("rst_hold", 32'(cpu_hold), 32'd1);
                check("rst_done", 32'(done), 32'd0);
                check("rst_err", 32'(err), 32'd0);
            end else begin
                check("rx_ready", 32'(rx_ready), 32'(exp_ready));
                check("i_write", 32'(i_write), 32'(exp_wr));
                check("cpu_hold", 32'(cpu_hold), 32'(exp_hold));
                check("done", 32'(done), 32'(exp_done));
                check("err", 32'(err), 32'(exp_err));
                if (exp_wr) begin
                    check("iaddr_write", 32'(iaddr_write), 32'(exp_addr));
                    check("idata_write", 32'(idata_write), 32'(exp_data));
                end
                if (i_write) begin
                    ram[iaddr_write] = idata_write;
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input role_t r);
        int g;
        bit ok;
        g = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
        idle(g);
        role_q.push_back(r);
        rx_data  = b;
        rx_valid = 1'b1;
        ok = 1'b0;
        for (int n = 0; n < 50 && !ok; n++) begin
            @(negedge clk);
            ok = rx_ready;
            @(posedge clk);
            #1;
        end
        rx_valid = 1'b0;
        if (!ok) begin
            check("handshake_timeout", 32'd0, 32'd1);
            role_q.delete();
        end
    endtask

    task automatic send_frame(input logic [7:0] cnt, input logic [15:0] words[$], input bit bad,
                              output logic [7:0] chk_out);
        int         nw;
        logic [7:0] sum;
        logic [7:0] lo;
        logic [7:0] hi;
        nw = (cnt == 8'h00) ? 256 : int'(cnt);
        send_byte(8'hA5, mk(R_SYNC, 8'h00, 16'h0000));
        send_byte(cnt, mk(R_PLAIN, 8'h00, 16'h0000));
        sum = cnt;
        for (int w = 0; w < nw; w++) begin
            lo = words[w][7:0];
            hi = words[w][15:8];
            send_byte(lo, mk(R_PLAIN, 8'h00, 16'h0000));
            send_byte(hi, mk(R_WORD, 8'(w), words[w]));
            sum = 8'(sum + lo + hi);
        end
        chk_out = 8'(8'h00 - sum);
        if (bad) begin
            chk_out = 8'(chk_out + 8'h01);
        end
        send_byte(chk_out, mk(bad ? R_BAD : R_GOOD, 8'h00, 16'h0000));
    endtask

    task automatic clear_ram();
        for (int i = 0; i < 256; i++) begin
            ram[i] = 16'hDEAD;
        end
    endtask

    initial begin
        logic [15:0] wq[$];
        logic [7:0]  c;
        logic [7:0]  j;
        bit          bad;
        role_t       ign;
        ign = mk(R_IGN, 8'h00, 16'h0000);
        clear_ram();

        // Power-on reset
        idle(3);
        reset = 1'b1;
        idle(2);

        // Good frame, back-to-back bytes
        gap_max = 0;
        wq = '{16'h1234, 16'h5678};
        send_frame(8'h02, wq, 1'b0, c);
        idle(3);
        check("good_chk_value", 32'(c), 32'h000000EA);
        check("good_ram0", 32'(ram[0]), 32'h1234);
        check("good_ram1", 32'(ram[1]), 32'h5678);
        check("good_hold", 32'(cpu_hold), 32'd0);
        check("good_done", 32'(done), 32'd1);

        // Bad checksum still writes the words
        gap_max = 3;
        clear_ram();
        send_frame(8'h02, wq, 1'b1, c);
        idle(3);
        check("bad_ram0", 32'(ram[0]), 32'h1234);
        check("bad_ram1", 32'(ram[1]), 32'h5678);
        check("bad_err", 32'(err), 32'd1);
        check("bad_hold", 32'(cpu_hold), 32'd1);
        check("bad_done", 32'(done), 32'd0);

        // Junk before SYNC
        send_byte(8'h00, ign);
        send_byte(8'hFF, ign);
        send_byte(8'h5A, ign);
        idle(2);
        check("junk_err_kept", 32'(err), 32'd1);
        send_frame(8'h02, wq, 1'b0, c);
        idle(3);
        check("junk_done", 32'(done), 32'd1);

        // COUNT=0 loads 256 words and wraps the address
        gap_max = 1;
        clear_ram();
        wq.delete();
        for (int i = 0; i < 256; i++) begin
            wq.push_back(16'(i));
        end
        send_frame(8'h00, wq, 1'b0, c);
        idle(3);
        check("c0_ram0", 32'(ram[0]), 32'h0000);
        check("c0_ram128", 32'(ram[128]), 32'h0080);
        check("c0_ram255", 32'(ram[255]), 32'h00FF);
        check("c0_addr_wrap", 32'(iaddr_write), 32'd0);
        check("c0_done", 32'(done), 32'd1);

        // Reset after the third data byte
        clear_ram();
        send_byte(8'hA5, mk(R_SYNC, 8'h00, 16'h0000));
        send_byte(8'h02, mk(R_PLAIN, 8'h00, 16'h0000));
        send_byte(8'h34, mk(R_PLAIN, 8'h00, 16'h0000));
        send_byte(8'h12, mk(R_WORD, 8'h00, 16'h1234));
        send_byte(8'h78, mk(R_PLAIN, 8'h00, 16'h0000));
        reset = 1'b0;
        idle(3);
        reset = 1'b1;
        idle(3);
        check("rst_ram0_kept", 32'(ram[0]), 32'h1234);
        check("rst_ram1_unwritten", 32'(ram[1]), 32'hDEAD);
        wq = '{16'hBEEF};
        send_frame(8'h01, wq, 1'b0, c);
        idle(3);
        check("rst_restart_ram0", 32'(ram[0]), 32'hBEEF);
        check("rst_restart_done", 32'(done), 32'd1);

        // Reload from RUN
        gap_max = 2;
        wq = '{16'hABCD};
        send_frame(8'h01, wq, 1'b0, c);
        idle(3);
        check("reload_chk_value", 32'(c), 32'h00000087);
        check("reload_ram0", 32'(ram[0]), 32'hABCD);
        check("reload_hold", 32'(cpu_hold), 32'd0);

        // Random frames with random gaps, junk and in-frame 0xA5 bytes
        for (int f = 0; f < 10; f++) begin
            gap_max = int'($urandom_range(3, 0));
            repeat ($urandom_range(2, 0)) begin
                j = 8'($urandom_range(255, 0));
                if (j == 8'hA5) begin
                    j = 8'h00;
                end
                send_byte(j, ign);
            end
            c = 8'($urandom_range(6, 1));
            wq.delete();
            for (int i = 0; i < int'(c); i++) begin
                wq.push_back(16'($urandom));
            end
            if (f % 2 == 0) begin
                wq[0][7:0] = 8'hA5;
            end
            bad = 1'($urandom_range(1, 0));
            send_frame(c, wq, bad, j);
            idle(3);
            check("rand_err", 32'(err), 32'(bad));
            check("rand_done", 32'(done), 32'(!bad));
        end

        idle(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
